// File: rtl/fas_pkg.sv
// Shared constants for the fas_n registered adder/subtractor slice.
package fas_pkg;

    localparam logic FAS_OP_ADD = 1'b0;
    localparam logic FAS_OP_SUB = 1'b1;

    localparam int unsigned FAS_DEFAULT_N = 32;

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full adder; one stage of the fas_n ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fas_n.sv
// N-bit registered adder/subtractor: ripple of full adders feeding an output register bank.
module fas_n
    import fas_pkg::*;
#(
    parameter int unsigned N = FAS_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         SEL,
    input  logic         CI,
    output logic [N-1:0] Y,
    output logic         CO,
    output logic         OV
);

    logic         is_sub;
    logic [N-1:0] bx;
    logic [N:0]   carry;
    logic [N-1:0] sum;

    logic [N-1:0] y_d, y_q;
    logic         co_d, co_q;
    logic         ov_d, ov_q;

    // Subtract is A + ~B + ~CI, so CI acts as a borrow-in and CO as not-borrow.
    assign is_sub   = (SEL == FAS_OP_SUB);
    assign bx       = B ^ {N{is_sub}};
    assign carry[0] = CI ^ is_sub;

    for (genvar i = 0; i < N; i++) begin : g_chain
        full_adder u_fa (
            .a    (A[i]),
            .b    (bx[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        y_d  = sum;
        co_d = carry[N];
        ov_d = carry[N] ^ carry[N-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q  <= '0;
            co_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            co_q <= co_d;
            ov_q <= ov_d;
        end
    end

    assign Y  = y_q;
    assign CO = co_q;
    assign OV = ov_q;

endmodule

// File: tb/tb_fas_n.sv
// Directed and randomized checks of fas_n (N=32) against an arithmetic reference model.
module tb_fas_n;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         SEL;
    logic         CI;
    logic [N-1:0] Y;
    logic         CO;
    logic         OV;

    int n_assert = 0;
    int n_fail   = 0;

    fas_n #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .SEL (SEL),
        .CI  (CI),
        .Y   (Y),
        .CO  (CO),
        .OV  (OV)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {OV, CO, Y} from plain integer arithmetic.
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic sel, input logic ci);
        longint ua, ub, sa, sb, r, u;
        logic [N-1:0] y;
        logic co, ov;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!sel) begin
            u  = ua + ub + longint'(ci);
            co = (u >= 64'sh1_0000_0000);
            r  = sa + sb + longint'(ci);
        end else begin
            co = (ua >= ub + longint'(ci));
            r  = sa - sb - longint'(ci);
            u  = ua - ub - longint'(ci);
        end
        y  = u[N-1:0];
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {ov, co, y};
    endfunction

    task automatic check(input string tag, input logic [N+1:0] exp);
        logic [N+1:0] obs;
        obs = {OV, CO, Y};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed OV=%b CO=%b Y=%h, expected OV=%b CO=%b Y=%h",
                   tag, obs[N+1], obs[N], obs[N-1:0], exp[N+1], exp[N], exp[N-1:0]);
        end
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic sel, input logic ci);
        A   = a;
        B   = b;
        SEL = sel;
        CI  = ci;
    endtask

    // Drive one op before the next edge, then sample 1 time unit after it.
    task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic sel, input logic ci, input logic [N+1:0] exp);
        drive(a, b, sel, ci);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    logic [N-1:0] ra, rb;
    logic         rs, rc;
    logic [N+1:0] prev;

    initial begin
        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", '0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations {OV, CO, Y}.
        op("add_min_min",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h0000_0000});
        op("add_carry",     32'h803F_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, {1'b0, 1'b1, 32'h803F_FFFE});
        op("add_ci_wrap",   32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000_0000});
        op("sub_neg_neg",   32'h8000_0040, 32'h8000_0018, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0028});
        op("sub_pos",       32'h603F_FFFF, 32'h1FFF_FFFF, 1'b1, 1'b0, {1'b0, 1'b1, 32'h4040_0000});
        op("sub_borrow",    32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, {1'b0, 1'b0, 32'hFFFF_FFFF});
        op("sub_ovf",       32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        op("sub_borrow_in", 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0002});

        // Input changes between edges must not reach the outputs.
        drive(32'h1234_5678, 32'h0FFF_0000, 1'b0, 1'b1);
        #2;
        check("hold_between_edges", {1'b0, 1'b1, 32'h0000_0002});

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", '0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        #2;
        check("before_first_edge", '0);
        @(posedge clk);
        #1;
        check("first_result", {1'b1, 1'b1, 32'h0000_0000});

        // Back-to-back ops: each result appears exactly one edge later.
        op("b2b_0", 32'h0000_0010, 32'h0000_0003, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_000D});
        op("b2b_1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        op("b2b_2", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0000_0008});

        // Randomized ops, biased toward sign/limit boundaries every few iterations.
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) ra = {ra[N-1], {(N-1){ra[0]}}};
            if (i % 5 == 0) rb = {rb[N-1], {(N-1){rb[0]}}};
            rs = 1'($urandom_range(1, 0));
            rc = 1'($urandom_range(1, 0));
            op("random", ra, rb, rs, rc, model(ra, rb, rs, rc));
        end

        // Mid-stream reset: the op present during reset is discarded.
        prev = {OV, CO, Y};
        drive(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_discards_op", '0);
        @(negedge clk);
        rst = 1'b0;
        op("after_reset", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, model(32'h1, 32'h1, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
